// File: rtl/ps2_entry_ctrl.sv
// Entry sequencer between a PS/2 byte receiver and the 13-slot scan-code register stage.
// Optional macro PS2_ENTRY_PAD_EN: a short entry (1..11 digits) is padded with 8'h29 on Enter.
module ps2_entry_ctrl #(
  parameter int DEPTH        = 13,
  parameter int IDLE_TIMEOUT = 50_000_000,
  parameter int ACK_TIMEOUT  = 64,
  parameter int TW           = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       ps2_done,
  input  logic [7:0] ps2_in_data,
  input  logic       ps2_out_en,
  output logic       mgr_en,
  output logic       mgr_done,
  output logic [7:0] mgr_data,
  output logic       busy,
  output logic [3:0] char_cnt,
  output logic       entry_done,
  output logic       err,
  output logic       reject
);

  // Handshakes: ps2_done and ps2_out_en are single-cycle strobes, sampled on
  // the clk rising edge with no back-pressure; mgr_done is a single-cycle
  // strobe qualifying mgr_data, always followed by at least one low cycle.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_COLLECT  = 3'd2,
    S_SKIP     = 3'd3,
    S_REPLAY   = 3'd4,
    S_WAIT_ACK = 3'd5
  } state_t;

  localparam logic [3:0]    FULL_CNT = 4'(DEPTH - 1);
  localparam logic [3:0]    LAST_IDX = 4'(DEPTH);
  localparam logic [TW-1:0] IDLE_LIM = TW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0] ACK_LIM  = TW'(ACK_TIMEOUT - 1);

  localparam logic [7:0] K_BREAK = 8'hF0;
  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_BKSP  = 8'h66;
  localparam logic [7:0] K_ESC   = 8'h76;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    rep_idx_q, rep_idx_d;
  logic          phase_q, phase_d;
  logic [7:0]    entry_q [DEPTH];
  logic [7:0]    entry_d [DEPTH];
  logic          mgr_en_q, mgr_en_d;
  logic          mgr_done_q, mgr_done_d;
  logic [7:0]    mgr_data_q, mgr_data_d;
  logic          busy_q, busy_d;
  logic          entry_done_q, entry_done_d;
  logic          err_q, err_d;
  logic          reject_q, reject_d;

  function automatic logic is_digit(input logic [7:0] b);
    case (b)
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
      8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h60, 8'h75, 8'h7D:
        is_digit = 1'b1;
      default: is_digit = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    rep_idx_d    = rep_idx_q;
    phase_d      = phase_q;
    entry_d      = entry_q;
    mgr_done_d   = 1'b0;
    mgr_data_d   = mgr_data_q;
    entry_done_d = 1'b0;
    err_d        = 1'b0;
    reject_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_CLEAR;
      end

      S_CLEAR: begin
        cnt_d   = 4'd0;
        tmr_d   = '0;
        state_d = S_COLLECT;
      end

      S_COLLECT, S_SKIP: begin
        if (ps2_done) begin
          // A received byte always restarts the idle timer, even on a timeout tie.
          tmr_d = '0;
          if (state_q == S_SKIP) begin
            state_d = S_COLLECT;
          end else if (ps2_in_data == K_BREAK) begin
            state_d = S_SKIP;
          end else if (ps2_in_data == K_EXT) begin
            state_d = S_COLLECT;
          end else if (is_digit(ps2_in_data)) begin
            if (cnt_q < FULL_CNT) begin
              entry_d[cnt_q] = ps2_in_data;
              cnt_d          = cnt_q + 4'd1;
            end else begin
              reject_d = 1'b1;
            end
          end else if (ps2_in_data == K_BKSP) begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               reject_d = 1'b1;
          end else if (ps2_in_data == K_ESC) begin
            cnt_d = 4'd0;
          end else if (ps2_in_data == K_ENTER) begin
            if (cnt_q == FULL_CNT) begin
              entry_d[DEPTH-1] = K_ENTER;
              rep_idx_d        = 4'd0;
              phase_d          = 1'b0;
              state_d          = S_REPLAY;
            end else begin
`ifdef PS2_ENTRY_PAD_EN
              if (cnt_q != 4'd0) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                  if (4'(i) >= cnt_q) entry_d[i] = 8'h29;
                end
                entry_d[DEPTH-1] = K_ENTER;
                rep_idx_d        = 4'd0;
                phase_d          = 1'b0;
                state_d          = S_REPLAY;
              end else begin
                reject_d = 1'b1;
              end
`else
              reject_d = 1'b1;
`endif
            end
          end
        end else if (tmr_q >= IDLE_LIM) begin
          // With nothing buffered the timer just parks at its limit.
          if (cnt_q != 4'd0) begin
            cnt_d   = 4'd0;
            tmr_d   = '0;
            err_d   = 1'b1;
            state_d = S_COLLECT;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      S_REPLAY: begin
        if (!phase_q) begin
          mgr_done_d = 1'b1;
          mgr_data_d = (rep_idx_q == LAST_IDX) ? 8'h00 : entry_q[rep_idx_q];
          if (rep_idx_q == LAST_IDX) begin
            // The trailing low cycle of the last strobe is the first WAIT_ACK cycle.
            tmr_d   = '0;
            state_d = S_WAIT_ACK;
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          phase_d   = 1'b0;
          rep_idx_d = rep_idx_q + 4'd1;
        end
      end

      S_WAIT_ACK: begin
        if (ps2_out_en) begin
          entry_done_d = 1'b1;
          state_d      = S_IDLE;
        end else if (tmr_q >= ACK_LIM) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    mgr_en_d = (state_d != S_CLEAR);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      tmr_q        <= '0;
      rep_idx_q    <= 4'd0;
      phase_q      <= 1'b0;
      mgr_en_q     <= 1'b0;
      mgr_done_q   <= 1'b0;
      mgr_data_q   <= 8'h00;
      busy_q       <= 1'b0;
      entry_done_q <= 1'b0;
      err_q        <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      rep_idx_q    <= rep_idx_d;
      phase_q      <= phase_d;
      mgr_en_q     <= mgr_en_d;
      mgr_done_q   <= mgr_done_d;
      mgr_data_q   <= mgr_data_d;
      busy_q       <= busy_d;
      entry_done_q <= entry_done_d;
      err_q        <= err_d;
      reject_q     <= reject_d;
    end
  end

  // Entry bytes carry no reset; they are only read after being written.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign mgr_en     = mgr_en_q;
  assign mgr_done   = mgr_done_q;
  assign mgr_data   = mgr_data_q;
  assign busy       = busy_q;
  assign char_cnt   = cnt_q;
  assign entry_done = entry_done_q;
  assign err        = err_q;
  assign reject     = reject_q;

endmodule

// File: tb/tb_ps2_entry_ctrl.sv
// Directed bench for ps2_entry_ctrl: vector table for key handling plus sequences for replay, timeouts and reset.
module tb_ps2_entry_ctrl;

  localparam int IDLE_TO = 100;
  localparam int ACK_TO  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       ps2_done = 1'b0;
  logic [7:0] ps2_in_data = 8'h00;
  logic       ps2_out_en = 1'b0;
  logic       mgr_en, mgr_done, busy, entry_done, err, reject;
  logic [7:0] mgr_data;
  logic [3:0] char_cnt;

  ps2_entry_ctrl #(
    .DEPTH(13), .IDLE_TIMEOUT(IDLE_TO), .ACK_TIMEOUT(ACK_TO), .TW(26)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .ps2_done(ps2_done),
    .ps2_in_data(ps2_in_data), .ps2_out_en(ps2_out_en),
    .mgr_en(mgr_en), .mgr_done(mgr_done), .mgr_data(mgr_data),
    .busy(busy), .char_cnt(char_cnt), .entry_done(entry_done),
    .err(err), .reject(reject)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];

  always @(negedge clk) begin
    if (rst_n && mgr_done) begin
      got_q.push_back(mgr_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, output logic rej);
    @(negedge clk);
    ps2_done = 1'b1;
    ps2_in_data = b;
    @(negedge clk);
    ps2_done = 1'b0;
    rej = reject;
  endtask

  task automatic do_arm();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic clear_capture();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("strobe_wait", got_q.size(), n);
  endtask

  task automatic check_burst(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
      if (i > 0) check($sformatf("%s_gap%0d", name, i), got_cyc[i] - got_cyc[i-1], 2);
    end
  endtask

  typedef struct {
    logic [7:0] code;
    logic [3:0] exp_cnt;
    logic       exp_rej;
  } vec_t;

  vec_t       vecs[26];
  logic [7:0] digits[12];
  logic       rej;
  int         k;
  int         n_err;

  initial begin
    digits = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45, 8'h16, 8'h1E};

    vecs[0]  = '{8'h16, 4'd1, 1'b0};
    vecs[1]  = '{8'h1E, 4'd2, 1'b0};
    vecs[2]  = '{8'h26, 4'd3, 1'b0};
    vecs[3]  = '{8'h66, 4'd2, 1'b0};
    vecs[4]  = '{8'h66, 4'd1, 1'b0};
    vecs[5]  = '{8'h45, 4'd2, 1'b0};
    vecs[6]  = '{8'h76, 4'd0, 1'b0};
    vecs[7]  = '{8'h66, 4'd0, 1'b1};
    vecs[8]  = '{8'hF0, 4'd0, 1'b0};
    vecs[9]  = '{8'h16, 4'd0, 1'b0};
    vecs[10] = '{8'hE0, 4'd0, 1'b0};
    vecs[11] = '{8'h5A, 4'd0, 1'b1};
    vecs[12] = '{8'h11, 4'd0, 1'b0};
    vecs[13] = '{8'h45, 4'd1, 1'b0};
    vecs[14] = '{8'h16, 4'd2, 1'b0};
    vecs[15] = '{8'h1E, 4'd3, 1'b0};
    vecs[16] = '{8'h26, 4'd4, 1'b0};
    vecs[17] = '{8'h25, 4'd5, 1'b0};
    vecs[18] = '{8'h2E, 4'd6, 1'b0};
    vecs[19] = '{8'h36, 4'd7, 1'b0};
    vecs[20] = '{8'h3D, 4'd8, 1'b0};
    vecs[21] = '{8'h3E, 4'd9, 1'b0};
    vecs[22] = '{8'h46, 4'd10, 1'b0};
    vecs[23] = '{8'h70, 4'd11, 1'b0};
    vecs[24] = '{8'h69, 4'd12, 1'b0};
    vecs[25] = '{8'h25, 4'd12, 1'b1};

    // reset state
    #1;
    check("rst_mgr_en", mgr_en, 0);
    check("rst_mgr_done", mgr_done, 0);
    check("rst_mgr_data", mgr_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_char_cnt", char_cnt, 0);
    check("rst_pulses", {entry_done, err, reject}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mgr_en_after_rst", mgr_en, 1);
    check("idle_busy", busy, 0);

    // full entry with break codes and acknowledge
    do_arm();
    check("clear_mgr_en", mgr_en, 0);
    check("clear_busy", busy, 1);
    clear_capture();
    for (int i = 0; i < 12; i++) begin
      send_byte(digits[i], rej);
      send_byte(8'hF0, rej);
      send_byte(digits[i], rej);
    end
    check("full_cnt", char_cnt, 12);
    send_byte(8'h5A, rej);
    for (int i = 0; i < 12; i++) exp_q.push_back(digits[i]);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h00);
    wait_strobes(14, 60);
    @(negedge clk);
    @(negedge clk);
    ps2_out_en = 1'b1;
    @(negedge clk);
    ps2_out_en = 1'b0;
    check("ack_entry_done", entry_done, 1);
    check("ack_busy", busy, 0);
    check("ack_err", err, 0);
    @(negedge clk);
    check("entry_done_width", entry_done, 0);
    repeat (4) @(negedge clk);
    check_burst("burst1");

    // table: backspace, escape, prefixes, overflow
    do_arm();
    clear_capture();
    for (int i = 0; i < 26; i++) begin
      send_byte(vecs[i].code, rej);
      check($sformatf("vec%0d_cnt", i), char_cnt, vecs[i].exp_cnt);
      check($sformatf("vec%0d_rej", i), rej, vecs[i].exp_rej);
      if (i == 5) check("vec5_slot1", dut.entry_q[1], 8'h45);
    end
    send_byte(8'hE0, rej);
    send_byte(8'h5A, rej);
    check("ext_enter_rej", rej, 0);
    for (int i = 13; i < 25; i++) exp_q.push_back(vecs[i].code);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h00);
    wait_strobes(14, 60);
    @(negedge clk);
    ps2_out_en = 1'b1;
    @(negedge clk);
    ps2_out_en = 1'b0;
    check("ack2_entry_done", entry_done, 1);
    check_burst("burst2");

    // short entry: padded or rejected
    do_arm();
    clear_capture();
    send_byte(8'h45, rej);
    send_byte(8'h16, rej);
    send_byte(8'h5A, rej);
`ifdef PS2_ENTRY_PAD_EN
    check("pad_rej", rej, 0);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h16);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'h29);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h00);
    wait_strobes(14, 60);
    @(negedge clk);
    ps2_out_en = 1'b1;
    @(negedge clk);
    ps2_out_en = 1'b0;
    check("pad_entry_done", entry_done, 1);
    check_burst("pad");
    do_arm();
`else
    check("short_rej", rej, 1);
    check("short_cnt", char_cnt, 2);
    repeat (40) @(negedge clk);
    check("short_no_strobes", got_q.size(), 0);
    send_byte(8'h76, rej);
`endif

    // idle timeout with a partial entry
    for (int i = 0; i < 5; i++) send_byte(digits[i], rej);
    check("part_cnt", char_cnt, 5);
    k = 0;
    while (!err && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("idle_err_seen", err, 1);
    check("idle_err_delay", k, IDLE_TO);
    check("idle_err_cnt", char_cnt, 0);
    check("idle_err_busy", busy, 1);
    @(negedge clk);
    check("idle_err_width", err, 0);
    n_err = 0;
    repeat (250) begin
      @(negedge clk);
      if (err) n_err++;
    end
    check("empty_timeout_quiet", n_err, 0);
    check("empty_timeout_busy", busy, 1);

    // replay with no acknowledge
    clear_capture();
    for (int i = 0; i < 12; i++) send_byte(digits[i], rej);
    send_byte(8'h5A, rej);
    wait_strobes(14, 60);
    k = 0;
    while (!err && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ack_to_err", err, 1);
    check("ack_to_delay", k, ACK_TO);
    check("ack_to_busy", busy, 0);
    check("ack_to_done", entry_done, 0);

    // reset in the middle of the replay
    do_arm();
    clear_capture();
    for (int i = 0; i < 12; i++) send_byte(digits[i], rej);
    send_byte(8'h5A, rej);
    wait_strobes(7, 40);
    check("mid_strobe_high", mgr_done, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mgr_en", mgr_en, 0);
    check("mid_rst_mgr_done", mgr_done, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_strobes", got_q.size(), 7);
    check("post_rst_mgr_en", mgr_en, 1);
    check("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
